mole_spawner: RTL and testbench

- Producer end of the board load interface: decides which moles pop up each round and drives `load`/`loadval` into the board-state register.
- Runs a round timer and a 16-bit LFSR pattern source.
- Watches the returned `board_state` to advance a round early when all moles are whacked, and to count moles left un-hit at round expiry (misses).
- Sits between the game-control FSM (`enable`, `level`) and the board-state block.

---
 rtl/mole_pkg.sv | 39 +++
 rtl/mole_lfsr16.sv | 26 ++
 rtl/mole_spawner.sv | 131 +++++++++++++
 tb/tb_mole_spawner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and helpers for the mole spawner: hole count, FSM state
// encoding, LFSR feedback taps, and the pattern/popcount helpers.
package mole_pkg;

  localparam int N_HOLES = 5;

  // Fibonacci feedback taps 16,14,13,11 (bit positions 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Number of set bits in a board snapshot.
  function automatic logic [2:0] popcount5(input logic [N_HOLES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Mole pattern from an LFSR value. An all-zero low field would produce an
  // empty round, so it is replaced by a single mole chosen from bits [7:5].
  function automatic logic [N_HOLES-1:0] mole_pattern(input logic [15:0] lfsr);
    logic [N_HOLES-1:0] p;
    logic [2:0]         sel;
    p   = lfsr[4:0];
    sel = lfsr[7:5] % 3'd5;
    if (p == '0) begin
      p = 5'b00001 << sel;
    end
    return p;
  endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// 16-bit Fibonacci LFSR. Loads the seed on reset (a zero seed is replaced by
// 1 so the register can never lock up) and shifts once per step pulse.
module mole_lfsr16
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic fb;

  assign fb = ^(value & LFSR_TAPS);

  // Shift register: seed on reset, advance only when stepped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (step) begin
      value <= {value[14:0], fb};
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: picks a new mole pattern each round, pulses load/loadval into
// the board register, times the round, ends it early once the board is
// cleared, and counts moles still standing when the round times out.
//
// state | meaning
// IDLE  | game stopped, no loads issued
// SPAWN | one cycle: register new pattern, reload round timer, step LFSR
// WAIT  | round running; leave on disable, timeout, or cleared board
module mole_spawner
  import mole_pkg::*;
#(
  parameter int          ROUND_TICKS = 50_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MISS_MAX    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         level,
  input  logic [N_HOLES-1:0] board_state,
  output logic               load,
  output logic [N_HOLES-1:0] loadval,
  output logic               round_pulse,
  output logic [7:0]         misses,
  output logic [7:0]         round_count
);

  localparam int TW = (ROUND_TICKS > 1) ? $clog2(ROUND_TICKS + 1) : 1;
  localparam logic [8:0] MISS_SAT = 9'(MISS_MAX);

  state_t          state_q;
  state_t          state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_reload;
  logic [31:0]     period;
  logic            first_wait_q;
  logic            lfsr_step;
  logic            expire;
  logic [15:0]     lfsr_value;
  logic [8:0]      miss_sum;

  mole_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .value (lfsr_value)
  );

  // Round length for the current level; never below one WAIT cycle.
  always_comb begin
    period       = 32'(ROUND_TICKS) >> level;
    timer_reload = (period > 32'd1) ? TW'(period - 32'd1) : TW'(1);
  end

  assign miss_sum = {1'b0, misses} + {6'b000000, popcount5(board_state)};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. The timer holds WAIT cycles left in the round; the round
  // times out on the cycle it counts down to zero. A cleared board is
  // ignored in the first WAIT cycle because the board register has not yet
  // taken the new pattern.
  always_comb begin
    state_d   = state_q;
    lfsr_step = 1'b0;
    expire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        lfsr_step = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (timer_q <= TW'(1)) begin
          expire  = 1'b1;
          state_d = SPAWN;
        end else if ((board_state == '0) && !first_wait_q) begin
          state_d = SPAWN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered pulses, pattern, counters and round timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load         <= 1'b0;
      loadval      <= '0;
      round_pulse  <= 1'b0;
      misses       <= 8'd0;
      round_count  <= 8'd0;
      timer_q      <= '0;
      first_wait_q <= 1'b0;
    end else begin
      load        <= (state_q == SPAWN);
      round_pulse <= (state_q == SPAWN);
      if (state_q == SPAWN) begin
        loadval      <= mole_pattern(lfsr_value);
        round_count  <= round_count + 8'd1;
        timer_q      <= timer_reload;
        first_wait_q <= 1'b1;
      end else if (state_q == WAIT) begin
        first_wait_q <= 1'b0;
        if (timer_q != '0) begin
          timer_q <= timer_q - TW'(1);
        end
      end
      if (expire) begin
        misses <= (miss_sum > MISS_SAT) ? MISS_SAT[7:0] : miss_sum[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner with an 8-cycle base round. Stimulus pushes the
// expected load (cycle, pattern, round count, misses) into a queue; a
// negedge monitor pops and compares each time the DUT pulses load.
module tb_mole_spawner;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] level;
  logic [4:0] board_state;
  logic       load;
  logic [4:0] loadval;
  logic       round_pulse;
  logic [7:0] misses;
  logic [7:0] round_count;

  mole_spawner #(
    .ROUND_TICKS (8),
    .LFSR_SEED   (16'hACE1),
    .MISS_MAX    (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .level       (level),
    .board_state (board_state),
    .load        (load),
    .loadval     (loadval),
    .round_pulse (round_pulse),
    .misses      (misses),
    .round_count (round_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int         cyc;
    logic [4:0] lv;
    logic [7:0] rc;
    logic [7:0] mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [15:0] m_lfsr;
  int          m_rc;
  int          m_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [4:0] pat(input logic [15:0] l);
    logic [4:0] p;
    int         s;
    p = l[4:0];
    s = int'(l[7:5]) % 5;
    if (p == 5'd0) p = 5'(1 << s);
    return p;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_rc   = 0;
    m_miss = 0;
  endtask

  // Queue the load expected at cycle c; add = moles missed at the expiry
  // that triggered it (0 for the first round or an early spawn).
  task automatic expect_load(input int c, input int add);
    exp_t e;
    e.cyc  = c;
    e.lv   = pat(m_lfsr);
    m_lfsr = lfsr_next(m_lfsr);
    m_rc   = (m_rc + 1) % 256;
    m_miss = m_miss + add;
    if (m_miss > 255) m_miss = 255;
    e.rc   = 8'(m_rc);
    e.mis  = 8'(m_miss);
    sb.push_back(e);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load"},        32'(load),        32'd0);
    chk({tag, "_loadval"},     32'(loadval),     32'd0);
    chk({tag, "_round_pulse"}, 32'(round_pulse), 32'd0);
    chk({tag, "_misses"},      32'(misses),      32'd0);
    chk({tag, "_round_count"}, 32'(round_count), 32'd0);
  endtask

  // Monitor: every load must match the head of the scoreboard.
  always @(negedge clk) begin
    if (load || round_pulse) begin
      chk("pulse_align", 32'(round_pulse), 32'(load));
      if (load) begin
        chk("loadval_nonzero", 32'(loadval != 5'd0), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_load", 32'(load), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("load_cycle",  32'(cyc),         32'(mon_e.cyc));
          chk("loadval",     32'(loadval),     32'(mon_e.lv));
          chk("round_count", 32'(round_count), 32'(mon_e.rc));
          chk("misses",      32'(misses),      32'(mon_e.mis));
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    level       = 2'd0;
    board_state = 5'd0;
    model_reset();

    goto_cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Two hits left standing at the first expiry; early spawn in round 2;
    // level 2 shortens round 3 to a single WAIT cycle.
    goto_cyc(5);
    enable      = 1'b1;
    board_state = 5'b00011;
    expect_load(7, 0);
    expect_load(15, 2);
    expect_load(19, 0);
    expect_load(21, 1);

    goto_cyc(15);
    board_state = 5'b00000;
    goto_cyc(16);
    board_state = 5'b00100;
    goto_cyc(17);
    board_state = 5'b00000;
    goto_cyc(18);
    board_state = 5'b10000;
    level       = 2'd2;
    goto_cyc(19);
    level       = 2'd3;

    // Level 3 rounds with a full board drive misses into saturation.
    goto_cyc(21);
    board_state = 5'b11111;
    for (int k = 1; k <= 60; k++) expect_load(21 + 2 * k, 5);

    goto_cyc(141);
    level = 2'd0;
    expect_load(143, 5);

    // Reset mid-round with enable still high.
    goto_cyc(145);
    rst = 1'b1;
    #1;
    check_reset_outputs("midround_reset");

    goto_cyc(147);
    rst = 1'b0;
    model_reset();
    expect_load(149, 0);

    // Drop enable mid-round: no further loads.
    goto_cyc(151);
    enable = 1'b0;

    // Long run of minimum-length rounds.
    goto_cyc(175);
    enable      = 1'b1;
    level       = 2'd3;
    board_state = 5'b00000;
    for (int i = 0; i < 1000; i++) expect_load(177 + 2 * i, 0);

    goto_cyc(2175);
    enable = 1'b0;
    goto_cyc(2190);
    chk("pending_loads", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
